// File: rtl/mem_uart_pkg.sv
// Shared types and constants for the memory <-> UART controllers.
// Defining MEM_UART_DUMP_CRLF_EN adds the CR/LF trailer states to the dump FSM.
package mem_uart_pkg;

   localparam int         DEFAULT_DEPTH = 4;
   localparam logic [7:0] ASCII_CR      = 8'h0D;
   localparam logic [7:0] ASCII_LF      = 8'h0A;

   typedef enum logic [3:0] {
      S_IDLE,
      S_ADDR,
      S_RDWAIT,
      S_SEND,
      S_HOLD,
      S_WAIT,
      S_NEXT,
`ifdef MEM_UART_DUMP_CRLF_EN
      S_CR,
      S_LF,
`endif
      S_FIN
   } dump_state_t;

   // Which byte the shared HOLD/WAIT handshake is currently finishing.
   typedef enum logic [1:0] {
      PH_DATA,
      PH_CR,
      PH_LF
   } dump_phase_t;

endpackage

// File: rtl/sw_rise_detect.sv
// Rising-edge pulse from an already synchronized, debounced push switch.
// The previous level is registered; the pulse is high for the cycle where the switch first reads 1.
module sw_rise_detect (
   input  logic clk,
   input  logic n_rst,
   input  logic i_sw,
   output logic o_rise
);

   logic r_sw_prev;

   // NOTE: flops use non-blocking assignments with an async active-low reset.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) r_sw_prev <= 1'b0;
      else        r_sw_prev <= i_sw;
   end

   assign o_rise = i_sw & ~r_sw_prev;

endmodule

// File: rtl/mem_uart_dump.sv
// Memory-to-UART dump: on a switch press, sends every valid memory byte to the UART TX.
// Defining MEM_UART_DUMP_CRLF_EN appends CR, LF after the data bytes.
module mem_uart_dump
   import mem_uart_pkg::*;
#(
   parameter int D_WIDTH = 8,
   parameter int A_WIDTH = 3,
   parameter int DEPTH   = DEFAULT_DEPTH
) (
   input  logic               clk,
   input  logic               n_rst,
   input  logic               push_sw,
   input  logic [A_WIDTH-1:0] wr_count,
   output logic [A_WIDTH-1:0] raddr,
   input  logic [D_WIDTH-1:0] rdata,
   output logic               tx_start,
   output logic [7:0]         tx_data,
   input  logic               tx_busy,
   output logic               busy,
   output logic               done
);

   dump_state_t        r_state, w_state_next;
   logic [A_WIDTH-1:0] r_idx, w_idx_next;
   logic [A_WIDTH-1:0] r_cnt, w_cnt_next, w_cnt_sat;
   logic [A_WIDTH-1:0] r_raddr;
   logic [7:0]         r_tx_data, w_tx_byte;
   logic               r_tx_start, r_busy, r_done;
   logic               w_rise, w_tx_load;
`ifdef MEM_UART_DUMP_CRLF_EN
   dump_phase_t        r_phase;
`endif

   sw_rise_detect u_sw_rise (
      .clk    (clk),
      .n_rst  (n_rst),
      .i_sw   (push_sw),
      .o_rise (w_rise)
   );

   assign w_cnt_sat = (wr_count > A_WIDTH'(DEPTH)) ? A_WIDTH'(DEPTH) : wr_count;

   always_comb begin
      // NOTE: every combinational output is defaulted first so no path infers a latch.
      w_state_next = r_state;
      w_idx_next   = r_idx;
      w_cnt_next   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_rise) begin
               w_cnt_next = w_cnt_sat;
               if (w_cnt_sat != '0) w_state_next = S_ADDR;
               else
`ifdef MEM_UART_DUMP_CRLF_EN
                  w_state_next = S_CR;
`else
                  w_state_next = S_FIN;
`endif
            end
         end
         S_ADDR:   w_state_next = S_RDWAIT;
         S_RDWAIT: w_state_next = S_SEND;
         S_SEND:   w_state_next = S_HOLD;
         S_HOLD:   w_state_next = S_WAIT;
         S_WAIT: begin
            if (!tx_busy) begin
`ifdef MEM_UART_DUMP_CRLF_EN
               case (r_phase)
                  PH_CR:   w_state_next = S_LF;
                  PH_LF:   w_state_next = S_FIN;
                  default: w_state_next = S_NEXT;
               endcase
`else
               w_state_next = S_NEXT;
`endif
            end
         end
         S_NEXT: begin
            if (r_idx == r_cnt - A_WIDTH'(1)) begin
`ifdef MEM_UART_DUMP_CRLF_EN
               w_state_next = S_CR;
`else
               w_state_next = S_FIN;
`endif
            end else begin
               w_idx_next   = r_idx + A_WIDTH'(1);
               w_state_next = S_ADDR;
            end
         end
`ifdef MEM_UART_DUMP_CRLF_EN
         S_CR:     w_state_next = S_HOLD;
         S_LF:     w_state_next = S_HOLD;
`endif
         S_FIN: begin
            w_idx_next   = '0;
            w_state_next = S_IDLE;
         end
         default:  w_state_next = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so each lines up with the state it belongs to.
   always_comb begin
      w_tx_load = 1'b0;
      w_tx_byte = rdata[7:0];
      case (w_state_next)
         S_SEND: w_tx_load = 1'b1;
`ifdef MEM_UART_DUMP_CRLF_EN
         S_CR: begin
            w_tx_load = 1'b1;
            w_tx_byte = ASCII_CR;
         end
         S_LF: begin
            w_tx_load = 1'b1;
            w_tx_byte = ASCII_LF;
         end
`endif
         default: w_tx_load = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state    <= S_IDLE;
         r_idx      <= '0;
         r_cnt      <= '0;
         r_raddr    <= '0;
         r_tx_data  <= 8'h00;
         r_tx_start <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
`ifdef MEM_UART_DUMP_CRLF_EN
         r_phase    <= PH_DATA;
`endif
      end else begin
         r_state    <= w_state_next;
         r_idx      <= w_idx_next;
         r_cnt      <= w_cnt_next;
         r_tx_start <= w_tx_load;
         r_busy     <= (w_state_next != S_IDLE);
         r_done     <= (w_state_next == S_FIN);
         if (w_state_next == S_ADDR) r_raddr   <= w_idx_next;
         if (w_tx_load)              r_tx_data <= w_tx_byte;
`ifdef MEM_UART_DUMP_CRLF_EN
         if (w_state_next == S_SEND)    r_phase <= PH_DATA;
         else if (w_state_next == S_CR) r_phase <= PH_CR;
         else if (w_state_next == S_LF) r_phase <= PH_LF;
`endif
      end
   end

   assign raddr    = r_raddr;
   assign tx_start = r_tx_start;
   assign tx_data  = r_tx_data;
   assign busy     = r_busy;
   assign done     = r_done;

endmodule

// File: tb/tb_mem_uart_dump.sv
// Self-checking bench for mem_uart_dump: table-driven dumps plus hand-written corner sequences.
// Expected CR/LF trailer bytes are added when MEM_UART_DUMP_CRLF_EN is defined.
module tb_mem_uart_dump;

   typedef struct {
      logic [2:0]      wc;
      int              blen;
      logic [3:0][7:0] m;
      int              exp_n;
   } vec_t;

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic       push_sw = 1'b0;
   logic       tx_busy = 1'b0;
   logic [2:0] wr_count = 3'd0;
   logic [2:0] raddr;
   logic [7:0] rdata = 8'h00;
   logic [7:0] tx_data;
   logic       tx_start, busy, done;

   logic [7:0] mem [8];
   int         cyc = 0;
   int         n_pass = 0;
   int         n_total = 0;
   int         busy_len = 1;
   int         busy_left = 0;
   logic       force_busy = 1'b0;
   int         press_cyc = 0;
   int         n_done = 0;
   int         done_cyc = 0;
   logic [7:0] got_q [$];
   int         got_cyc [$];

   always #5 clk = ~clk;

   mem_uart_dump dut (
      .clk      (clk),
      .n_rst    (n_rst),
      .push_sw  (push_sw),
      .wr_count (wr_count),
      .raddr    (raddr),
      .rdata    (rdata),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .tx_busy  (tx_busy),
      .busy     (busy),
      .done     (done)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous-read memory: data valid the cycle after raddr.
   always @(posedge clk) rdata <= mem[raddr];

   // Transmitter model: busy for busy_len cycles starting in the tx_start cycle.
   always @(negedge clk) begin
      if (tx_start)           busy_left = busy_len;
      else if (busy_left > 0) busy_left = busy_left - 1;
      tx_busy = (busy_left > 0) || force_busy;
   end

   always @(negedge clk) begin
      if (n_rst && tx_start) begin
         got_q.push_back(tx_data);
         got_cyc.push_back(cyc);
      end
      if (n_rst && done) begin
         n_done   = n_done + 1;
         done_cyc = cyc;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic clear_obs();
      got_q.delete();
      got_cyc.delete();
      n_done = 0;
   endtask

   task automatic press();
      @(negedge clk);
      push_sw   = 1'b1;
      press_cyc = cyc;
      @(negedge clk);
      push_sw   = 1'b0;
   endtask

   task automatic wait_done(input string name, input int max);
      int t = 0;
      while (n_done == 0 && t < max) begin
         @(negedge clk);
         t++;
      end
      check({name, "_done_seen"}, 32'(n_done > 0), 32'd1);
   endtask

   task automatic wait_bytes(input string name, input int n, input int max);
      int t = 0;
      while (got_q.size() < n && t < max) begin
         @(negedge clk);
         t++;
      end
      check({name, "_bytes_seen"}, 32'(got_q.size() >= n), 32'd1);
   endtask

   function automatic int trailer_n();
`ifdef MEM_UART_DUMP_CRLF_EN
      return 2;
`else
      return 0;
`endif
   endfunction

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      vec_t       vecs [6];
      logic [7:0] exp_q [$];
      logic [2:0] last_raddr;
      logic       acc_start, acc_busy, acc_done;
      logic [2:0] acc_raddr;
      logic [7:0] acc_data;
      string      nm;

      vecs[0] = '{wc: 3'd4, blen: 10, m: 32'h44434241, exp_n: 4};
      vecs[1] = '{wc: 3'd0, blen: 4,  m: 32'h44434241, exp_n: 0};
      vecs[2] = '{wc: 3'd2, blen: 1,  m: 32'hFF005AA5, exp_n: 2};
      vecs[3] = '{wc: 3'd7, blen: 3,  m: 32'h40302010, exp_n: 4};
      vecs[4] = '{wc: 3'd1, blen: 5,  m: 32'h3332317E, exp_n: 1};
      vecs[5] = '{wc: 3'd5, blen: 2,  m: 32'hC3B2A190, exp_n: 4};

      for (int k = 0; k < 8; k++) mem[k] = 8'hEE;

      repeat (3) @(negedge clk);
      n_rst = 1'b1;

      // Reset state and 10 idle cycles.
      acc_start = 1'b0; acc_busy = 1'b0; acc_done = 1'b0;
      acc_raddr = '0;   acc_data = '0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         acc_start |= tx_start;
         acc_busy  |= busy;
         acc_done  |= done;
         acc_raddr |= raddr;
         acc_data  |= tx_data;
      end
      check("idle_tx_start", 32'(acc_start), 32'd0);
      check("idle_busy",     32'(acc_busy),  32'd0);
      check("idle_done",     32'(acc_done),  32'd0);
      check("idle_raddr",    32'(acc_raddr), 32'd0);
      check("idle_tx_data",  32'(acc_data),  32'd0);

      // Table-driven dumps.
      last_raddr = 3'd0;
      foreach (vecs[i]) begin
         for (int k = 0; k < 4; k++) mem[k] = vecs[i].m[k];
         wr_count = vecs[i].wc;
         busy_len = vecs[i].blen;
         clear_obs();
         press();
         nm = $sformatf("v%0d", i);
         wait_done(nm, 300);
         repeat (3) @(negedge clk);

         exp_q.delete();
         for (int k = 0; k < vecs[i].exp_n; k++) exp_q.push_back(vecs[i].m[k]);
`ifdef MEM_UART_DUMP_CRLF_EN
         exp_q.push_back(8'h0D);
         exp_q.push_back(8'h0A);
`endif
         check({nm, "_nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
         for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
            check($sformatf("%s_byte%0d", nm, k), 32'(got_q[k]), 32'(exp_q[k]));
         check({nm, "_done_once"}, 32'(n_done), 32'd1);
         check({nm, "_busy_after"}, 32'(busy), 32'd0);
         if (vecs[i].exp_n > 0) begin
            last_raddr = 3'(vecs[i].exp_n - 1);
            if (got_cyc.size() > 0)
               check({nm, "_first_lat"}, 32'(got_cyc[0] - press_cyc), 32'd3);
         end
         check({nm, "_raddr_hold"}, 32'(raddr), 32'(last_raddr));
         if (vecs[i].exp_n >= 2 && got_cyc.size() >= 2)
            check({nm, "_gap"}, 32'(got_cyc[1] - got_cyc[0]),
                  32'(((vecs[i].blen > 2) ? vecs[i].blen : 2) + 4));
         if (exp_q.size() > 0)
            check({nm, "_tx_data_hold"}, 32'(tx_data), 32'(exp_q[exp_q.size() - 1]));
`ifndef MEM_UART_DUMP_CRLF_EN
         if (vecs[i].exp_n == 0)
            check({nm, "_done_lat"}, 32'(done_cyc - press_cyc), 32'd1);
`endif
      end

      // Second press and wr_count change mid-dump are ignored.
      for (int k = 0; k < 4; k++) mem[k] = 8'h41 + 8'(k);
      wr_count = 3'd2;
      busy_len = 4;
      clear_obs();
      press();
      wait_bytes("ign", 1, 50);
      wr_count = 3'd4;
      push_sw  = 1'b1;
      @(negedge clk);
      push_sw  = 1'b0;
      wait_done("ign", 300);
      repeat (5) @(negedge clk);
      check("ign_nbytes", 32'(got_q.size()), 32'(2 + trailer_n()));
      check("ign_done_once", 32'(n_done), 32'd1);

      // Transmitter stuck busy after byte 2.
      wr_count = 3'd4;
      busy_len = 2;
      clear_obs();
      press();
      wait_bytes("stuck", 2, 100);
      force_busy = 1'b1;
      repeat (1000) @(negedge clk);
      check("stuck_nbytes", 32'(got_q.size()), 32'd2);
      check("stuck_busy", 32'(busy), 32'd1);
      check("stuck_no_done", 32'(n_done), 32'd0);
      force_busy = 1'b0;
      wait_done("stuck", 300);
      repeat (3) @(negedge clk);
      check("stuck_total", 32'(got_q.size()), 32'(4 + trailer_n()));
      if (got_q.size() > 2) check("stuck_byte2", 32'(got_q[2]), 32'h43);

      // Reset during WAIT of byte 2, then restart.
      busy_len = 6;
      clear_obs();
      press();
      wait_bytes("rst", 2, 100);
      repeat (3) @(negedge clk);
      check("rst_pre_busy", 32'(busy), 32'd1);
      n_rst = 1'b0;
      #1;
      check("rst_raddr",    32'(raddr),    32'd0);
      check("rst_tx_data",  32'(tx_data),  32'd0);
      check("rst_tx_start", 32'(tx_start), 32'd0);
      check("rst_busy",     32'(busy),     32'd0);
      check("rst_done",     32'(done),     32'd0);
      @(negedge clk);
      n_rst = 1'b1;
      repeat (8) @(negedge clk);
      busy_len = 1;
      clear_obs();
      press();
      wait_done("restart", 300);
      repeat (3) @(negedge clk);
      check("restart_nbytes", 32'(got_q.size()), 32'(4 + trailer_n()));
      if (got_q.size() > 0)   check("restart_byte0", 32'(got_q[0]), 32'h41);
      if (got_cyc.size() > 0) check("restart_first_lat", 32'(got_cyc[0] - press_cyc), 32'd3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
